// File: rtl/probe_capture_if.sv
// Signal bundle between a probe source / readout agent and probe_capture.
//
// Readout handshake: rd_en is a one-cycle request sampled on the rising edge
// while done=1. Each accepted request yields exactly one rd_valid pulse, with
// rd_data, on the following cycle. There is no backpressure. Requests made
// outside DONE, or together with abort or arm, are dropped without a response.
interface probe_capture_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] probe;
    logic             arm;
    logic             abort;
    logic [WIDTH-1:0] trig_mask;
    logic [WIDTH-1:0] trig_value;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             busy;
    logic             done;
    logic             triggered;

    // Stimulus / readout side
    modport master (
        output probe, arm, abort, trig_mask, trig_value, rd_en,
        input  rd_data, rd_valid, busy, done, triggered
    );

    // Capture engine side
    modport slave (
        input  probe, arm, abort, trig_mask, trig_value, rd_en,
        output rd_data, rd_valid, busy, done, triggered
    );
endinterface

// File: rtl/probe_capture.sv
// Logic-analyzer endpoint: records a trigger-centred window of DEPTH samples
// (PRE_TRIGGER before the trigger, the trigger sample, the rest after) into a
// circular buffer, then plays the window back oldest-first on request.
// dbg_state exposes the FSM: 0 IDLE, 1 FILL, 2 WAIT, 3 POST, 4 DONE.
module probe_capture #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int PRE_TRIGGER = 4
) (
    input  logic                clk,
    input  logic                reset,
    probe_capture_if.slave      bus,
    output logic [2:0]          dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // With no pre-trigger history there is nothing to fill, so arm goes
    // straight to trigger search.
    localparam state_t          ARM_TARGET = (PRE_TRIGGER == 0) ? S_WAIT : S_FILL;
    localparam logic [PW-1:0]   PRE_OFF    = PW'(PRE_TRIGGER);
    localparam logic [CW-1:0]   FILL_LAST  = CW'((PRE_TRIGGER > 0) ? PRE_TRIGGER - 1 : 0);
    localparam logic [CW-1:0]   POST_LEN   = CW'(DEPTH - PRE_TRIGGER - 1);
    localparam logic [CW-1:0]   RD_LAST    = CW'(DEPTH - 1);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

    state_t           state;
    state_t           next_state;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    start_ptr;
    logic [CW-1:0]    fill_cnt;
    logic [CW-1:0]    post_cnt;
    logic [CW-1:0]    rd_count;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             triggered_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic trig_hit;
    logic sampling;
    logic arming;
    logic rd_accept;

    // Qualifiers shared by the state register, datapath and buffer write.
    always_comb begin
        trig_hit  = ((bus.probe ^ bus.trig_value) & bus.trig_mask) == '0;
        sampling  = !bus.abort &&
                    (state == S_FILL || state == S_WAIT || state == S_POST);
        arming    = !bus.abort && bus.arm && (state == S_IDLE || state == S_DONE);
        rd_accept = !bus.abort && !bus.arm && bus.rd_en && (state == S_DONE);
    end

    // Next-state logic; abort dominates everything, arm dominates readout.
    always_comb begin
        next_state = state;
        if (bus.abort) begin
            next_state = S_IDLE;
        end else if (arming) begin
            next_state = ARM_TARGET;
        end else begin
            case (state)
                S_IDLE: next_state = S_IDLE;
                S_FILL: if (fill_cnt == FILL_LAST) next_state = S_WAIT;
                S_WAIT: if (trig_hit) next_state = (POST_LEN == '0) ? S_DONE : S_POST;
                S_POST: if (post_cnt == CNT_ONE) next_state = S_DONE;
                S_DONE: if (rd_accept && rd_count == RD_LAST) next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Sample buffer; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (sampling) mem[wptr] <= bus.probe;
    end

    // Pointers, counters, trigger flag and registered readout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr        <= '0;
            rptr        <= '0;
            start_ptr   <= '0;
            fill_cnt    <= '0;
            post_cnt    <= '0;
            rd_count    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (bus.abort) begin
                triggered_q <= 1'b0;
            end else if (arming) begin
                wptr        <= '0;
                fill_cnt    <= '0;
                triggered_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        wptr     <= '0;
                        fill_cnt <= '0;
                    end
                    S_FILL: begin
                        wptr     <= wptr + 1'b1;
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                    S_WAIT: begin
                        wptr <= wptr + 1'b1;
                        if (trig_hit) begin
                            // Window starts PRE_TRIGGER samples before this one.
                            start_ptr   <= wptr - PRE_OFF;
                            rptr        <= wptr - PRE_OFF;
                            rd_count    <= '0;
                            post_cnt    <= POST_LEN;
                            triggered_q <= 1'b1;
                        end
                    end
                    S_POST: begin
                        wptr     <= wptr + 1'b1;
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == CNT_ONE) begin
                            rptr     <= start_ptr;
                            rd_count <= '0;
                        end
                    end
                    S_DONE: begin
                        if (rd_accept) begin
                            rd_data_q  <= mem[rptr];
                            rd_valid_q <= 1'b1;
                            rptr       <= rptr + 1'b1;
                            rd_count   <= rd_count + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status and readout outputs.
    always_comb begin
        bus.rd_data   = rd_data_q;
        bus.rd_valid  = rd_valid_q;
        bus.busy      = (state == S_FILL) || (state == S_WAIT) || (state == S_POST);
        bus.done      = (state == S_DONE);
        bus.triggered = triggered_q;
        dbg_state     = state;
    end
endmodule

// File: doc/probe_capture.md
Name: probe_capture

Overview:
- Debug capture stage sitting directly downstream of routed probe signals: receives a bus of routed wires (e.g. aba/abb/abc collected in a leaf module) and records a trigger-centred window into an internal circular buffer.
- Provides pre-trigger history, a mask/value trigger and in-order readout.
- Intended as the standard logic-analyzer endpoint instantiated wherever routed signals terminate.

Parameters:
WIDTH, 8, probe/sample width in bits
DEPTH, 16, buffer depth in samples; power of 2, >= 2
PRE_TRIGGER, 4, samples kept before the trigger sample; 0 <= PRE_TRIGGER < DEPTH

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
probe  input  WIDTH  routed signals to sample
arm  input  1  pulse; starts a capture from IDLE or DONE
abort  input  1  pulse; returns to IDLE from any state
trig_mask  input  WIDTH  1 = bit participates in trigger compare
trig_value  input  WIDTH  required value of masked bits
rd_en  input  1  read one sample; honoured only in DONE
rd_data  output  WIDTH  sample read out, registered
rd_valid  output  1  rd_data valid this cycle
busy  output  1  high in FILL, WAIT, POST
done  output  1  high in DONE
triggered  output  1  high from trigger detection until next arm/abort/reset

Behaviour:
- Reset (reset=0, async): state IDLE; rd_data=0, rd_valid=0, busy=0, done=0, triggered=0; write/read pointers and counters 0. Buffer contents undefined, not cleared.
- States: IDLE, FILL, WAIT, POST, DONE.
- IDLE:
  - arm=1 -> FILL, or WAIT if PRE_TRIGGER=0.
  - wptr<=0, count<=0.
- Sampling: each cycle in FILL, WAIT and POST, mem[wptr]<=probe and wptr<=(wptr+1) mod DEPTH. The arm cycle itself is not sampled.
- FILL:
  - Trigger ignored, so the full pre-trigger window is guaranteed.
  - After PRE_TRIGGER samples written -> WAIT.
- WAIT:
  - Buffer wraps freely.
  - Trigger = ((probe ^ trig_value) & trig_mask) == 0, evaluated combinationally on the sampled value.
  - On trigger: that sample is written; start <= (wptr - PRE_TRIGGER) mod DEPTH; triggered<=1; post count <= DEPTH-PRE_TRIGGER-1.
  - Next state is POST, or DONE if the post count is 0.
  - trig_mask=0 triggers on the first WAIT cycle.
- POST:
  - Writes the remaining samples, decrementing the post count.
  - Count reaches 0 on write -> DONE; rptr<=start, rd_count<=0.
  - Total stored = DEPTH contiguous samples: PRE_TRIGGER before the trigger, the trigger sample, then DEPTH-PRE_TRIGGER-1 after it.
- DONE:
  - done=1. No sampling.
  - rd_en=1 in cycle n: rd_data=mem[rptr] and rd_valid=1 in cycle n+1; rptr wraps mod DEPTH.
  - rd_valid=0 in any cycle without an accepted read.
  - Accepting the DEPTH-th read -> IDLE (done falls the next cycle; the last rd_valid still occurs). triggered stays 1 in IDLE until the next arm.
- rd_en outside DONE: ignored, no rd_valid, pointers unchanged.
- arm in FILL/WAIT/POST: ignored.
- arm in DONE: readout abandoned, new capture starts as from IDLE.
- abort:
  - Any state -> IDLE next cycle; triggered<=0.
  - abort overrides arm and rd_en in the same cycle; no rd_valid is generated for a read coincident with abort.
- Simultaneous trigger and abort in WAIT: abort wins, no trigger recorded.
- Reset mid-capture or mid-readout: immediate IDLE, all outputs at reset values.
- Pointers are log2(DEPTH) bits, natural wrap. Counters are sized to hold DEPTH.

Test Plan:
1. Normal capture, defaults:
   - Stimulus: probe = free-running 8-bit counter; arm when probe=0x10; mask=0xFF, value=0x20.
   - Required: busy 1 from next cycle; done asserted the cycle after sample 0x2B is written; 16 back-to-back reads return 0x1C..0x2B with rd_valid each cycle one cycle after rd_en; done=0 after the last read.
2. Immediate trigger:
   - Stimulus: mask=0x00.
   - Required: trigger on first WAIT sample (probe 0x15 if armed at 0x10); readout 0x11..0x20.
3. Masked trigger:
   - Stimulus: mask=0x0F, value=0x0A, armed at 0x10.
   - Required: sample 0x1A triggers; readout 0x16..0x25.
4. Abort:
   - Stimulus: abort asserted during WAIT, simultaneously with a matching probe.
   - Required: IDLE next cycle; busy=0, triggered=0, done never asserted; later rd_en gives no rd_valid.
5. Reset and ignored arm:
   - Stimulus: reset=0 asynchronously mid-POST; after release, arm again.
   - Required: all outputs 0 immediately on reset; after release, a clean capture matching scenario 1.
   - Stimulus: arm pulsed during POST.
   - Required: no effect.
6. Partial readout then re-arm:
   - Stimulus: 5 reads in DONE (returning the first 5 samples in order), then arm.
   - Required: new capture starts, triggered cleared; PRE_TRIGGER=0 build variant goes straight to WAIT and stores the trigger sample first.
